bus_timer_irq: RTL and testbench

BUS_TIMER_IRQ -- requirements
Module: bus_timer_irq

---
 rtl/bus_timer_irq.sv | 179 +++++++++++++++++
 tb/tb_bus_timer_irq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_timer_irq.sv
// bus_timer_irq: CPU-addressable 16-bit down-counting timer with level interrupt
// and an optional watchdog that raises a non-maskable interrupt.
//
// Register map (address):
//   0 TLO   reload low byte (R/W)
//   1 THI   reload high byte (R/W); writing it loads reload and count
//   2 CTRL  bit0 EN, bit1 AUTO, bit2 IEN (R/W)
//   3 STAT  bit0 TF, write 1 to clear
//   4 WDOG  watchdog kick (8'hA5) / armed status
//   5 CNTLO count[7:0]; reading latches count[15:8] into a shadow
//   6 CNTHI shadow of count[15:8]
//   7 reserved, reads 8'h00
//
// Build option: define WATCHDOG_EN to include the watchdog. Without it nmi is
// tied low and WDOG reads 8'h00.

module bus_timer_irq #(
  parameter logic [15:0] WDT_CYCLES = 16'hFFFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic [2:0] address,
  input  logic       write,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       irq,
  output logic       nmi
);

  localparam logic [2:0] A_TLO   = 3'd0;
  localparam logic [2:0] A_THI   = 3'd1;
  localparam logic [2:0] A_CTRL  = 3'd2;
  localparam logic [2:0] A_STAT  = 3'd3;
  localparam logic [2:0] A_WDOG  = 3'd4;
  localparam logic [2:0] A_CNTLO = 3'd5;
  localparam logic [2:0] A_CNTHI = 3'd6;

  logic [7:0]  r_tlo;
  logic [7:0]  r_thi;
  logic [15:0] r_reload;
  logic [15:0] r_count;
  logic        r_en;
  logic        r_auto;
  logic        r_ien;
  logic        r_tf;
  logic [7:0]  r_shadow;

  logic        w_wr;
  logic        w_rd;
  logic        w_wr_tlo;
  logic        w_wr_thi;
  logic        w_wr_ctrl;
  logic        w_wr_stat;
  logic        w_rd_cntlo;
  logic        w_tick;
  logic [7:0]  w_wdog_rd;

  assign w_wr       = cs & write;
  assign w_rd       = cs & ~write;
  assign w_wr_tlo   = w_wr & (address == A_TLO);
  assign w_wr_thi   = w_wr & (address == A_THI);
  assign w_wr_ctrl  = w_wr & (address == A_CTRL);
  assign w_wr_stat  = w_wr & (address == A_STAT);
  assign w_rd_cntlo = w_rd & (address == A_CNTLO);

  // Terminal-count event: the counter sits at zero while enabled.
  assign w_tick = r_en & (r_count == 16'd0);

  // Reload byte registers; reload only takes effect when the high byte is written.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tlo    <= 8'h00;
      r_thi    <= 8'h00;
      r_reload <= 16'h0000;
    end else begin
      if (w_wr_tlo) r_tlo <= data_i;
      if (w_wr_thi) begin
        r_thi    <= data_i;
        r_reload <= {data_i, r_tlo};
      end
    end
  end

  // Down-counter: a THI write overrides any decrement or auto-reload on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 16'h0000;
    end else if (w_wr_thi) begin
      r_count <= {data_i, r_tlo};
    end else if (r_en) begin
      if (r_count != 16'd0) r_count <= r_count - 16'd1;
      else if (r_auto)      r_count <= r_reload;
    end
  end

  // Control bits; a one-shot terminal count drops EN unless the CPU rewrites CTRL.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en   <= 1'b0;
      r_auto <= 1'b0;
      r_ien  <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_en   <= data_i[0];
      r_auto <= data_i[1];
      r_ien  <= data_i[2];
    end else if (w_tick && !r_auto) begin
      r_en   <= 1'b0;
    end
  end

  // Timer flag: a set event beats a simultaneous write-1-to-clear.
  always_ff @(posedge clk) begin
    if (reset)                         r_tf <= 1'b0;
    else if (w_tick)                   r_tf <= 1'b1;
    else if (w_wr_stat && data_i[0])   r_tf <= 1'b0;
  end

  // High-byte shadow captured on every CNTLO read for tear-free 16-bit reads.
  always_ff @(posedge clk) begin
    if (reset)           r_shadow <= 8'h00;
    else if (w_rd_cntlo) r_shadow <= r_count[15:8];
  end

  assign irq = r_tf & r_ien;

`ifdef WATCHDOG_EN
  logic        r_armed;
  logic [15:0] r_wcount;
  logic        r_nmi;
  logic        w_kick;

  assign w_kick = w_wr & (address == A_WDOG) & (data_i == 8'hA5);

  // Watchdog: a kick reloads the timeout; expiry latches nmi until the next kick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_armed  <= 1'b0;
      r_wcount <= 16'h0000;
      r_nmi    <= 1'b0;
    end else if (w_kick) begin
      r_armed  <= 1'b1;
      r_wcount <= WDT_CYCLES;
      r_nmi    <= 1'b0;
    end else if (r_armed) begin
      if (r_wcount != 16'd0) r_wcount <= r_wcount - 16'd1;
      else                   r_nmi    <= 1'b1;
    end
  end

  assign nmi       = r_nmi;
  assign w_wdog_rd = {7'b0, r_armed};
`else
  assign nmi       = 1'b0;
  assign w_wdog_rd = 8'h00;
`endif

  // Read mux: only a CPU read cycle drives data; everything else reads zero.
  // NOTE: data_o gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    data_o = 8'h00;
    if (w_rd) begin
      case (address)
        A_TLO:   data_o = r_tlo;
        A_THI:   data_o = r_thi;
        A_CTRL:  data_o = {5'b0, r_ien, r_auto, r_en};
        A_STAT:  data_o = {7'b0, r_tf};
        A_WDOG:  data_o = w_wdog_rd;
        A_CNTLO: data_o = r_count[7:0];
        A_CNTHI: data_o = r_shadow;
        default: data_o = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_timer_irq.sv
// Testbench for bus_timer_irq. Bus reads push their expected {irq, nmi, data}
// into a scoreboard queue; a negedge monitor pops and compares whenever a read
// cycle is on the bus. Watchdog checks are compiled in with WATCHDOG_EN.

module tb_bus_timer_irq;

  localparam logic [2:0] A_TLO   = 3'd0;
  localparam logic [2:0] A_THI   = 3'd1;
  localparam logic [2:0] A_CTRL  = 3'd2;
  localparam logic [2:0] A_STAT  = 3'd3;
  localparam logic [2:0] A_WDOG  = 3'd4;
  localparam logic [2:0] A_CNTLO = 3'd5;
  localparam logic [2:0] A_CNTHI = 3'd6;
  localparam logic [2:0] A_RSVD  = 3'd7;

  logic       clk;
  logic       reset;
  logic       cs;
  logic [2:0] address;
  logic       write;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       irq;
  logic       nmi;

  int n_checks = 0;
  int n_fail   = 0;

  string      name_q[$];
  logic [9:0] exp_q[$];   // {irq, nmi, data}

  bus_timer_irq #(.WDT_CYCLES(16'd10)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .address (address),
    .write   (write),
    .data_i  (data_i),
    .data_o  (data_o),
    .irq     (irq),
    .nmi     (nmi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Monitor: compares every read cycle against the scoreboard, and checks the
  // bus stays quiet whenever cs is low.
  always @(negedge clk) begin
    if (cs && !write) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: read at address %0d with no expectation", address);
      end else begin
        string      nm;
        logic [9:0] e;
        nm = name_q.pop_front();
        e  = exp_q.pop_front();
        check({nm, ".data"}, data_o, e[7:0]);
        check({nm, ".irq"},  {7'b0, irq}, {7'b0, e[9]});
        check({nm, ".nmi"},  {7'b0, nmi}, {7'b0, e[8]});
      end
    end else if (!cs) begin
      check("idle_data", data_o, 8'h00);
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; write = 1'b1; address = a; data_i = d;
    @(posedge clk); #1;
    cs = 1'b0; write = 1'b0; data_i = 8'h00;
  endtask

  task automatic bus_read(input string name, input logic [2:0] a, input logic [7:0] exp_d,
                          input logic exp_irq, input logic exp_nmi);
    name_q.push_back(name);
    exp_q.push_back({exp_irq, exp_nmi, exp_d});
    cs = 1'b1; write = 1'b0; address = a;
    @(posedge clk); #1;
    cs = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cs = 1'b0; write = 1'b0; address = 3'd0; data_i = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Post-reset: every register reads zero, no interrupts.
    for (int a = 0; a < 8; a++) bus_read($sformatf("rst_a%0d", a), 3'(a), 8'h00, 1'b0, 1'b0);

    // Register readback; TLO alone leaves count alone; unused CTRL bits read 0.
    bus_write(A_TLO, 8'h5A);
    bus_write(A_THI, 8'hC3);
    bus_read("rb_tlo",   A_TLO,   8'h5A, 1'b0, 1'b0);
    bus_read("rb_thi",   A_THI,   8'hC3, 1'b0, 1'b0);
    bus_read("rb_cntlo", A_CNTLO, 8'h5A, 1'b0, 1'b0);
    bus_read("rb_cnthi", A_CNTHI, 8'hC3, 1'b0, 1'b0);
    bus_write(A_TLO, 8'h11);
    bus_read("tlo_only_tlo",   A_TLO,   8'h11, 1'b0, 1'b0);
    bus_read("tlo_only_cntlo", A_CNTLO, 8'h5A, 1'b0, 1'b0);
    bus_read("tlo_only_cnthi", A_CNTHI, 8'hC3, 1'b0, 1'b0);
    bus_write(A_CTRL, 8'hFE);
    bus_read("ctrl_mask", A_CTRL, 8'h06, 1'b0, 1'b0);
    bus_write(A_CTRL, 8'h00);
    bus_write(A_RSVD, 8'hFF);
    bus_read("rsvd", A_RSVD, 8'h00, 1'b0, 1'b0);

    // Auto-reload 3 with interrupt: TF/irq four cycles after EN, period 4.
    bus_write(A_TLO, 8'h03);
    bus_write(A_THI, 8'h00);
    bus_write(A_CTRL, 8'h07);
    bus_read("per_c0_cnt",  A_CNTLO, 8'h03, 1'b0, 1'b0);
    bus_read("per_c1_cnt",  A_CNTLO, 8'h02, 1'b0, 1'b0);
    bus_read("per_c2_stat", A_STAT,  8'h00, 1'b0, 1'b0);
    bus_read("per_c3_cnt",  A_CNTLO, 8'h00, 1'b0, 1'b0);
    bus_read("per_c4_stat", A_STAT,  8'h01, 1'b1, 1'b0);
    bus_read("per_c5_cnt",  A_CNTLO, 8'h02, 1'b1, 1'b0);
    bus_write(A_STAT, 8'h01);
    bus_read("per_c7_clr",  A_STAT,  8'h00, 1'b0, 1'b0);
    bus_read("per_c8_stat", A_STAT,  8'h01, 1'b1, 1'b0);
    bus_write(A_CTRL, 8'h00);
    bus_write(A_STAT, 8'h01);
    bus_read("per_off", A_STAT, 8'h00, 1'b0, 1'b0);

    // One-shot from 2: TF after 3 cycles, EN self-clears, count parks at 0.
    bus_write(A_TLO, 8'h02);
    bus_write(A_THI, 8'h00);
    bus_write(A_CTRL, 8'h01);
    bus_read("os_c0_stat",  A_STAT,  8'h00, 1'b0, 1'b0);
    bus_read("os_c1_cnt",   A_CNTLO, 8'h01, 1'b0, 1'b0);
    bus_read("os_c2_stat",  A_STAT,  8'h00, 1'b0, 1'b0);
    bus_read("os_c3_stat",  A_STAT,  8'h01, 1'b0, 1'b0);
    bus_read("os_c4_ctrl",  A_CTRL,  8'h00, 1'b0, 1'b0);
    bus_read("os_c5_cntlo", A_CNTLO, 8'h00, 1'b0, 1'b0);
    bus_read("os_c6_cnthi", A_CNTHI, 8'h00, 1'b0, 1'b0);
    bus_write(A_STAT, 8'h01);

    // Atomic 16-bit read across the 0x0100 -> 0x00FF borrow.
    bus_write(A_TLO, 8'h00);
    bus_write(A_THI, 8'h01);
    bus_write(A_CTRL, 8'h01);
    bus_read("atom_lo0", A_CNTLO, 8'h00, 1'b0, 1'b0);
    bus_read("atom_hi0", A_CNTHI, 8'h01, 1'b0, 1'b0);
    bus_read("atom_lo1", A_CNTLO, 8'hFE, 1'b0, 1'b0);
    bus_read("atom_hi1", A_CNTHI, 8'h00, 1'b0, 1'b0);
    bus_write(A_CTRL, 8'h00);

    // Reload 0 with AUTO: TF sets every cycle and beats the clear.
    bus_write(A_TLO, 8'h00);
    bus_write(A_THI, 8'h00);
    bus_write(A_CTRL, 8'h03);
    bus_read("r0_c0_stat", A_STAT, 8'h00, 1'b0, 1'b0);
    bus_write(A_STAT, 8'h01);
    bus_write(A_STAT, 8'h01);
    bus_write(A_STAT, 8'h01);
    bus_read("r0_setwins", A_STAT, 8'h01, 1'b0, 1'b0);
    bus_write(A_CTRL, 8'h07);
    bus_read("r0_irq", A_STAT, 8'h01, 1'b1, 1'b0);

    // Reset while running (TF set event coincides with the reset edge).
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int a = 0; a < 8; a++) bus_read($sformatf("midrst_a%0d", a), 3'(a), 8'h00, 1'b0, 1'b0);

`ifdef WATCHDOG_EN
    // WDT_CYCLES=10: nmi 11 cycles after kick; 5A ignored; kick clears nmi.
    bus_write(A_WDOG, 8'hA5);
    bus_read("wd_c0_armed", A_WDOG, 8'h01, 1'b0, 1'b0);
    idle(9);
    bus_read("wd_c10", A_RSVD, 8'h00, 1'b0, 1'b0);
    bus_read("wd_c11", A_RSVD, 8'h00, 1'b0, 1'b1);
    bus_write(A_WDOG, 8'h5A);
    bus_read("wd_5a_ignored", A_WDOG, 8'h01, 1'b0, 1'b1);
    bus_write(A_WDOG, 8'hA5);
    bus_read("wd_rekick", A_WDOG, 8'h01, 1'b0, 1'b0);
`else
    bus_write(A_WDOG, 8'hA5);
    bus_read("wd_absent", A_WDOG, 8'h00, 1'b0, 1'b0);
    idle(3);
    bus_read("wd_absent_nmi", A_RSVD, 8'h00, 1'b0, 1'b0);
`endif

    idle(2);
    check("sb_drained", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
